// File: rtl/stack_controller.sv
// LIFO controller in front of a synchronous single-port RAM; push takes 1 busy cycle, pop 2 busy cycles with data_valid 3 cycles after grant.
// No backpressure: requests are sampled only in IDLE; overflow/underflow attempts are dropped and latch error_flag.
module stack_controller #(
  parameter int REGISTER_SIZE = 2,
  parameter int DATA_SIZE     = 8
) (
  input  logic                     control_clock,
  input  logic                     reset,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic [DATA_SIZE-1:0]     data_in,
  input  logic                     clear_error,
  input  logic [DATA_SIZE-1:0]     ram_rdata,
  output logic [REGISTER_SIZE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0]     ram_wdata,
  output logic                     ram_we,
  output logic                     ram_re,
  output logic [DATA_SIZE-1:0]     data_out,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [REGISTER_SIZE:0]   stack_count,
  output logic                     error_flag
);

  localparam logic [REGISTER_SIZE:0] DEPTH = {1'b1, {REGISTER_SIZE{1'b0}}};

  typedef enum logic [1:0] {IDLE, PUSH, POP_ADDR, POP_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [REGISTER_SIZE:0] count_q, count_d;
  logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
  logic [DATA_SIZE-1:0]   dout_q, dout_d;
  logic                   dvalid_q, dvalid_d;
  logic                   err_q, err_d;
  logic                   prio_push_q, prio_push_d;

  logic push_ok, pop_ok, grant_push, grant_pop;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);

  // Round-robin only matters when both requests are legal.
  assign push_ok    = push_req && !full;
  assign pop_ok     = pop_req && !empty;
  assign grant_push = push_ok && (!pop_ok || prio_push_q);
  assign grant_pop  = pop_ok && !grant_push;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wdata_d     = wdata_q;
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    err_d       = clear_error ? 1'b0 : err_q;
    prio_push_d = prio_push_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (grant_push) begin
          state_d     = PUSH;
          wdata_d     = data_in;
          prio_push_d = 1'b0;
        end else if (grant_pop) begin
          state_d     = POP_ADDR;
          prio_push_d = 1'b1;
        end
        if ((push_req && full && !grant_pop) || (pop_req && empty && !grant_push)) begin
          err_d = 1'b1;
        end
      end
      PUSH: begin
        ram_we    = 1'b1;
        ram_addr  = count_q[REGISTER_SIZE-1:0];
        ram_wdata = wdata_q;
        count_d   = count_q + 1'b1;
        state_d   = IDLE;
      end
      POP_ADDR: begin
        ram_re   = 1'b1;
        ram_addr = REGISTER_SIZE'(count_q - 1'b1);
        count_d  = count_q - 1'b1;
        state_d  = POP_WAIT;
      end
      POP_WAIT: begin
        dout_d   = ram_rdata;
        dvalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge control_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wdata_q     <= '0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      prio_push_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      err_q       <= err_d;
      prio_push_q <= prio_push_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign stack_count = count_q;
  assign data_out    = dout_q;
  assign data_valid  = dvalid_q;
  assign error_flag  = err_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: a transaction-level stack model (queue of words plus a plan of
// expected busy cycles) is compared against every DUT output once per cycle, on the falling edge.
module tb_stack_controller;
  localparam int RS = 2;
  localparam int DS = 8;
  localparam int DEPTH = 1 << RS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          push_req, pop_req, clear_error;
  logic [DS-1:0] data_in;
  logic [DS-1:0] ram_rdata = '0;
  logic [RS-1:0] ram_addr;
  logic [DS-1:0] ram_wdata, data_out;
  logic          ram_we, ram_re, data_valid, busy, full, empty, error_flag;
  logic [RS:0]   stack_count;

  stack_controller #(.REGISTER_SIZE(RS), .DATA_SIZE(DS)) dut (
    .control_clock(clk), .reset(rst_n), .push_req(push_req), .pop_req(pop_req),
    .data_in(data_in), .clear_error(clear_error), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .full(full),
    .empty(empty), .stack_count(stack_count), .error_flag(error_flag)
  );

  logic [DS-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // One entry per expected busy cycle; delta is applied to the count when the cycle ends.
  typedef struct {
    bit we; bit re; int addr; int wdata; int delta; bit fire; int val;
  } step_t;

  step_t plan[$];
  int    stk[$];
  int    m_count, m_dout;
  bit    m_err, m_dv, last_pop;
  int    n_chk = 0;
  int    n_fail = 0;
  int    pop_exp[3] = '{'h33, 'h22, 'h11};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    plan.delete();
    stk.delete();
    m_count = 0; m_dout = 0; m_err = 0; m_dv = 0; last_pop = 1;
  endtask

  task automatic model_step(input bit p, input bit q, input int d, input bit c);
    step_t e;
    int g;
    m_dv = 0;
    if (c) m_err = 0;
    if (plan.size() > 0) begin
      e = plan.pop_front();
      m_count += e.delta;
      if (e.fire) begin m_dout = e.val; m_dv = 1; end
    end else begin
      bit pok, qok;
      pok = p && (m_count < DEPTH);
      qok = q && (m_count > 0);
      g = 0;
      if (pok && qok) g = last_pop ? 1 : 2;
      else if (pok) g = 1;
      else if (qok) g = 2;
      if (p && !pok && g != 2) m_err = 1;
      if (q && !qok && g != 1) m_err = 1;
      if (g == 1) begin
        e = '{default: 0};
        e.we = 1; e.addr = m_count; e.wdata = d; e.delta = 1;
        plan.push_back(e);
        stk.push_back(d);
        last_pop = 0;
      end else if (g == 2) begin
        e = '{default: 0};
        e.re = 1; e.addr = m_count - 1; e.delta = -1;
        plan.push_back(e);
        e = '{default: 0};
        e.fire = 1; e.val = stk.pop_back();
        plan.push_back(e);
        last_pop = 1;
      end
    end
  endtask

  task automatic compare();
    step_t cur;
    bit b;
    b = plan.size() > 0;
    cur = '{default: 0};
    if (b) cur = plan[0];
    chk("busy", busy, b);
    chk("ram_we", ram_we, cur.we);
    chk("ram_re", ram_re, cur.re);
    chk("ram_addr", ram_addr, cur.addr);
    chk("ram_wdata", ram_wdata, cur.wdata);
    chk("data_valid", data_valid, m_dv);
    chk("data_out", data_out, m_dout);
    chk("stack_count", stack_count, m_count);
    chk("full", full, m_count == DEPTH);
    chk("empty", empty, m_count == 0);
    chk("error_flag", error_flag, m_err);
  endtask

  task automatic tick(input bit p, input bit q, input int d, input bit c);
    push_req = p; pop_req = q; data_in = DS'(d); clear_error = c;
    @(posedge clk);
    model_step(p, q, d & 'hFF, c);
    @(negedge clk);
    compare();
  endtask

  initial begin
    rst_n = 0; push_req = 0; pop_req = 0; clear_error = 0; data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare();
    chk("rst_empty", empty, 1);
    rst_n = 1;

    // Three pushes land at addresses 0,1,2.
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 'h11 * (i + 1), 0);
      chk("push_we", ram_we, 1);
      chk("push_addr", ram_addr, i);
      chk("push_busy", busy, 1);
      tick(0, 0, 0, 0);
    end
    chk("cnt3", stack_count, 3);

    // Pops return LIFO order, data_valid in the third cycle after the grant edge.
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0);
      chk("pop_re", ram_re, 1);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      chk("pop_dv", data_valid, 1);
      chk("pop_data", data_out, pop_exp[i]);
    end
    chk("empty_after_pops", empty, 1);

    // Fill, then overflow.
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 0, 'hA0 + i, 0);
      tick(0, 0, 0, 0);
    end
    tick(1, 0, 'h55, 0);
    chk("ovf_full", full, 1);
    chk("ovf_no_we", ram_we, 0);
    chk("ovf_err", error_flag, 1);
    tick(1, 0, 'h56, 1);
    chk("clr_and_err", error_flag, 1);
    tick(0, 0, 0, 1);
    chk("clr_err", error_flag, 0);

    // Full with both requests: pop wins, no error.
    tick(1, 1, 'h66, 0);
    chk("full_both_pop", ram_re, 1);
    chk("full_both_noerr", error_flag, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("cnt2", stack_count, 2);

    // Held simultaneous requests alternate; last grant was pop so push comes first.
    tick(1, 1, 'h90, 0);
    chk("alt_first_push", ram_we, 1);
    repeat (14) tick(1, 1, $urandom_range(0, 255), 0);
    repeat (3) tick(0, 0, 0, 0);

    for (int i = 0; i < 8 && m_count > 0; i++) begin
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
    end
    tick(0, 1, 0, 0);
    chk("udf_no_re", ram_re, 0);
    chk("udf_err", error_flag, 1);
    chk("udf_cnt", stack_count, 0);
    tick(0, 0, 0, 1);

    // Reset in the middle of POP_ADDR.
    tick(1, 0, 'h77, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    chk("pre_rst_re", ram_re, 1);
    rst_n = 0;
    #1;
    chk("rst_re_drop", ram_re, 0);
    chk("rst_cnt", stack_count, 0);
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1;
    repeat (4) tick(0, 0, 0, 0);

    repeat (800) begin
      tick($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
           $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
